// File: rtl/mmss_timer.sv
// ---------------------------------------------------------------------------
// mmss_timer
//   Minutes:seconds countdown/countup timer for the front-panel display path.
//   A preset is loaded at run time, then the timer is started, paused and
//   resumed on exact cycles. A one-cycle expiry pulse marks the terminal
//   count. The time is presented as four BCD digits for the seven-segment
//   scan driver.
//
//   Build option:
//     TIMER_WARN_EN  defined   -> warn output is generated
//                    undefined -> warn is tied low and WARN_SEC is unused
//
//   Parameters:
//     CLK_HZ     clock cycles per one-second tick (>= 2)
//     WARN_SEC   remaining-seconds threshold for warn (down mode only)
//
//   Ports:
//     clk         system clock, rising edge
//     rstn        asynchronous active-low reset
//     load        strobe: load clamped preset, latch mode, go to IDLE
//     start       strobe: IDLE/PAUSE -> RUN
//     pause       strobe: RUN -> PAUSE
//     mode_up     sampled on load: 0 = count down, 1 = count up
//     preset_min  preset minutes (clamped to 99)
//     preset_sec  preset seconds (clamped to 59)
//     bcd_time    {min_tens, min_units, sec_tens, sec_units}, decoded from count
//     running     high in RUN
//     done        high in DONE
//     expired     one-cycle pulse on entry to DONE
//     warn        down mode, RUN/PAUSE, 0 < count <= WARN_SEC
// ---------------------------------------------------------------------------
module mmss_timer #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned WARN_SEC = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic        mode_up,
    input  logic [6:0]  preset_min,
    input  logic [5:0]  preset_sec,
    output logic [15:0] bcd_time,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic        warn
);

    localparam int unsigned CNT_W = 13;
    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    // Elaboration-time parameter sanity checks
    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("mmss_timer: CLK_HZ must be at least 2");
    end
    if (WARN_SEC > 5999) begin : g_bad_warn_sec
        $error("mmss_timer: WARN_SEC must not exceed 5999");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state,  state_nxt;
    logic [CNT_W-1:0]   count,  count_nxt;
    logic [CNT_W-1:0]   target, target_nxt;
    logic [PRE_W-1:0]   presc,  presc_nxt;
    logic               mode_q, mode_nxt;

    logic               running_nxt;
    logic               done_nxt;
    logic               expired_nxt;

    logic [6:0]         min_clamp;
    logic [5:0]         sec_clamp;
    logic [CNT_W-1:0]   preset_val;
    logic               tick;
    logic [CNT_W-1:0]   count_step;

    // Preset clamp and conversion to seconds
    always_comb begin
        min_clamp  = (preset_min > 7'd99) ? 7'd99 : preset_min;
        sec_clamp  = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
        preset_val = CNT_W'(min_clamp) * CNT_W'(60) + CNT_W'(sec_clamp);
    end

    // One-second tick and the count value it would produce
    always_comb begin
        tick       = (state == S_RUN) && (presc == PRE_MAX);
        count_step = mode_q ? (count + CNT_W'(1)) : (count - CNT_W'(1));
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            count  <= '0;
            target <= '0;
            presc  <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            target <= target_nxt;
            presc  <= presc_nxt;
            mode_q <= mode_nxt;
        end
    end

    // Next-state and datapath update; load overrides everything, pause beats start
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        target_nxt = target;
        presc_nxt  = presc;
        mode_nxt   = mode_q;

        if (load) begin
            // A tick coinciding with load is dropped: the reload wins.
            mode_nxt  = mode_up;
            presc_nxt = '0;
            state_nxt = S_IDLE;
            if (mode_up) begin
                count_nxt  = '0;
                target_nxt = preset_val;
            end else begin
                count_nxt  = preset_val;
                target_nxt = '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (count != target)) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    presc_nxt = tick ? '0 : (presc + PRE_W'(1));
                    if (tick) begin
                        count_nxt = count_step;
                    end
                    // The terminal tick takes precedence over a coincident
                    // pause so the count can never run past the target.
                    if (tick && (count_step == target)) begin
                        state_nxt = S_DONE;
                    end else if (pause) begin
                        state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state, registered below
    always_comb begin
        running_nxt = (state_nxt == S_RUN);
        done_nxt    = (state_nxt == S_DONE);
        expired_nxt = (state_nxt == S_DONE) && (state != S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            running <= running_nxt;
            done    <= done_nxt;
            expired <= expired_nxt;
        end
    end

`ifdef TIMER_WARN_EN
    localparam logic [CNT_W-1:0] WARN_CNT = CNT_W'(WARN_SEC);

    logic warn_nxt;

    // Low-time warning, evaluated on the values the registers are about to take
    always_comb begin
        warn_nxt = !mode_nxt
                && ((state_nxt == S_RUN) || (state_nxt == S_PAUSE))
                && (count_nxt != '0)
                && (count_nxt <= WARN_CNT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            warn <= 1'b0;
        end else begin
            warn <= warn_nxt;
        end
    end
`else
    assign warn = 1'b0;
`endif

    // Seconds count to four BCD digits; zero latency relative to count
    logic [6:0] disp_min;
    logic [5:0] disp_sec;

    always_comb begin
        disp_min = 7'(count / CNT_W'(60));
        disp_sec = 6'(count % CNT_W'(60));
        bcd_time = {4'(disp_min / 7'd10), 4'(disp_min % 7'd10),
                    4'(disp_sec / 6'd10), 4'(disp_sec % 6'd10)};
    end

endmodule

// File: tb/tb_mmss_timer.sv
// ---------------------------------------------------------------------------
// tb_mmss_timer
//   Directed self-checking bench for mmss_timer with CLK_HZ = 10.
//   Expected seconds values are queued when stimulus is applied and popped
//   as each count change appears on bcd_time.
// ---------------------------------------------------------------------------
module tb_mmss_timer;

    localparam int unsigned CLK_HZ   = 10;
    localparam int unsigned WARN_SEC = 10;

`ifdef TIMER_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        load;
    logic        start;
    logic        pause;
    logic        mode_up;
    logic [6:0]  preset_min;
    logic [5:0]  preset_sec;
    logic [15:0] bcd_time;
    logic        running;
    logic        done;
    logic        expired;
    logic        warn;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    mmss_timer #(
        .CLK_HZ   (CLK_HZ),
        .WARN_SEC (WARN_SEC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .start      (start),
        .pause      (pause),
        .mode_up    (mode_up),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .bcd_time   (bcd_time),
        .running    (running),
        .done       (done),
        .expired    (expired),
        .warn       (warn)
    );

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic exp_warn(input int s, input logic up);
        return WARN_EN && !up && (s != 0) && (s <= int'(WARN_SEC));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] eb,
                               input logic er, input logic ed,
                               input logic ee, input logic ew);
        check({tag, "/bcd"}, bcd_time, eb);
        check({tag, "/flags(run,done,exp,warn)"},
              {12'h000, running, done, expired, warn},
              {12'h000, er, ed, ee, ew});
    endtask

    // Advance n rising edges, then settle just after the last one
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic up, input logic [6:0] m, input logic [5:0] s);
        mode_up    = up;
        preset_min = m;
        preset_sec = s;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Pop each queued second, wait (bounded) for bcd_time to change, compare
    task automatic run_changes(input string tag, input int interval, input logic up);
        while (exp_q.size() > 0) begin
            int          s;
            int          n;
            logic [15:0] prev;
            bit          seen;
            s    = exp_q.pop_front();
            prev = bcd_time;
            n    = 0;
            seen = 1'b0;
            while (!seen && (n < interval + 5)) begin
                step();
                n++;
                if (bcd_time !== prev) seen = 1'b1;
            end
            check({tag, "/bcd"}, bcd_time, to_bcd(s));
            check({tag, "/gap"}, 16'(n), 16'(interval));
            check({tag, "/warn"}, {15'h0000, warn}, {15'h0000, exp_warn(s, up)});
        end
    endtask

    initial begin
        int pulses;

        rstn       = 1'b0;
        load       = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        mode_up    = 1'b0;
        preset_min = 7'd0;
        preset_sec = 6'd0;
        step(3);
        check_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        step(2);

        // Reset does not load a preset: count == target, so start is ignored
        do_start();
        step(3);
        check_state("reset_start", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Countdown from 0:03
        do_load(1'b0, 7'd0, 6'd3);
        check_state("dn_load", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        do_start();
        check_state("dn_start", 16'h0003, 1'b1, 1'b0, 1'b0, WARN_EN);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(0);
        run_changes("dn", 10, 1'b0);
        check_state("dn_expire", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check_state("dn_done", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        repeat (20) begin
            step();
            if (expired) pulses++;
        end
        check("dn_extra_pulses", 16'(pulses), 16'd0);
        check_state("dn_hold", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Count up to 1:05, then start in DONE is ignored
        do_load(1'b1, 7'd1, 6'd5);
        check_state("up_load", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_start();
        check_state("up_start", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 1; s <= 65; s++) exp_q.push_back(s);
        run_changes("up", 10, 1'b1);
        check_state("up_expire", 16'h0105, 1'b0, 1'b1, 1'b1, 1'b0);
        do_start();
        step(3);
        check_state("up_done_start", 16'h0105, 1'b0, 1'b1, 1'b0, 1'b0);

        // Clamping and a zero preset
        do_load(1'b0, 7'd120, 6'd63);
        check_state("clamp", 16'h9959, 1'b0, 1'b0, 1'b0, 1'b0);
        do_load(1'b0, 7'd0, 6'd0);
        do_start();
        step(12);
        check_state("zero_start", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pause 4 cycles after start, hold 50, resume: first tick after 6 cycles
        do_load(1'b0, 7'd0, 6'd5);
        do_start();
        step(3);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_state("paused", 16'h0005, 1'b0, 1'b0, 1'b0, WARN_EN);
        step(50);
        check_state("pause_hold", 16'h0005, 1'b0, 1'b0, 1'b0, WARN_EN);
        do_start();
        check_state("resume", 16'h0005, 1'b1, 1'b0, 1'b0, WARN_EN);
        exp_q.push_back(4);
        run_changes("resume", 6, 1'b0);

        // Pause coinciding with the next tick: tick applied, state PAUSE
        step(9);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check_state("pause_on_tick", 16'h0003, 1'b0, 1'b0, 1'b0, WARN_EN);
        step(20);
        check_state("pause_tick_hold", 16'h0003, 1'b0, 1'b0, 1'b0, WARN_EN);

        // Load and start together: load wins, block sits in IDLE
        mode_up    = 1'b0;
        preset_min = 7'd0;
        preset_sec = 6'd7;
        load       = 1'b1;
        start      = 1'b1;
        step();
        load       = 1'b0;
        start      = 1'b0;
        check_state("load_start", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);
        step(15);
        check_state("load_start_idle", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        do_start();
        step(15);
        check_state("pre_reset", 16'h0006, 1'b1, 1'b0, 1'b0, WARN_EN);
        rstn = 1'b0;
        #1;
        check_state("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3);
        check_state("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        step();

        // Warning window on a countdown from 0:12
        do_load(1'b0, 7'd0, 6'd12);
        do_start();
        check_state("warn_start", 16'h0012, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int s = 11; s >= 0; s--) exp_q.push_back(s);
        run_changes("warn", 10, 1'b0);
        check_state("warn_done", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmss_timer.md
# mmss_timer

Parametrised minutes:seconds timer for the front-panel display path. It counts down or up from a preset that is loaded at run time. Start, pause and resume are cycle-exact, and an expiry pulse is generated at the terminal count. The time is presented as four BCD digits ready for the seven-segment scan driver, and the block sits between the switch/button conditioning logic and the display mux.

## Interface
Parameters:
- CLK_HZ, 50_000_000, clock cycles per one-second tick (≥2)
- WARN_SEC, 10, remaining-seconds threshold for `warn` (down mode only)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  reset; asynchronous and active-low
- load  input  1  one-cycle strobe; loads preset, latches mode, enters IDLE
- start  input  1  one-cycle strobe; IDLE/PAUSE → RUN
- pause  input  1  one-cycle strobe; RUN → PAUSE
- mode_up  input  1  sampled on `load`: 0 = count down preset→0, 1 = count up 0→preset
- preset_min  input  7  minutes, clamped to 99
- preset_sec  input  6  seconds, clamped to 59
- bcd_time  output  16  {min_tens, min_units, sec_tens, sec_units}
- running  output  1  high in RUN
- done  output  1  high in DONE
- expired  output  1  one-cycle pulse on DONE entry
- warn  output  1  down mode, RUN or PAUSE, count ≤ WARN_SEC and count ≠ 0

## Operation
- Internal count is in seconds, 13 bits, range 0..5999; target is 13 bits.
- The prescaler counts 0..CLK_HZ-1 and generates `tick` when it equals CLK_HZ-1 in RUN; it then wraps to 0.
- `load` behaviour:
  - Clamp the preset: P = min(preset_min,99)*60 + min(preset_sec,59).
  - Down mode: count←P, target←0.
  - Up mode: count←0, target←P.
  - Prescaler←0 and state←IDLE.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: `start` with count≠target → RUN. If count==target, `start` is ignored.
  - RUN: on each tick, count decrements (down mode) or increments (up mode). When the tick makes count==target, the next state is DONE. `pause` → PAUSE.
  - PAUSE: prescaler and count are frozen. `start` → RUN, and the prescaler resumes from its held value.
  - DONE: count holds at the target. Only `load` or reset leaves this state.
- Priority when strobes coincide: load > pause > start.
  - `load` on the same cycle as a tick: the load wins and the tick is discarded.
  - `pause` on the same cycle as a tick: the tick is applied and the state becomes PAUSE.
- `bcd_time` is a combinational decode of count: min = count/60, sec = count%60, each split into tens and units digits.
- `load` in RUN or PAUSE aborts the run and reloads immediately.

## Timing
- Reset values:
  - count = 0, target = 0, prescaler = 0, latched mode = down, state = IDLE.
  - bcd_time = 16'h0000; running, done, expired, warn = 0.
  - Reset does not load the preset.
- `start` sampled at edge N gives running=1 from N+1. The first count change is at edge N+CLK_HZ, and each later change follows CLK_HZ cycles after the previous one.
- The terminal tick at edge M updates count and sets state to DONE at the same edge. From M+1 `done`=1, and `expired`=1 during M+1 only.
- Pausing at prescaler value k and resuming gives the next tick CLK_HZ-1-k RUN cycles after resume. The total RUN time per second is always exactly CLK_HZ cycles.
- `bcd_time` has zero cycles of latency relative to count.
- `rstn` deasserted mid-run clears everything asynchronously. No expiry pulse is produced.

## Configuration
- TIMER_WARN_EN defined: `warn` is generated as specified above.
- TIMER_WARN_EN undefined: `warn` is tied to 0 and no comparator logic is synthesised. WARN_SEC is then unused.

## Test plan
- CLK_HZ=10; load down mode with 0 min 3 s, then start:
  - bcd_time steps 0003→0002→0001→0000 every 10 cycles.
  - expired pulses once, one cycle after the 0000 edge.
  - done stays high.
- Up mode with preset 1:05:
  - Counts from 0000 to 0105 in 65 ticks, then DONE.
  - A start issued in DONE is ignored.
- Clamping: preset_min=120, preset_sec=63 loads 9959 (5999 s). Load 0:00 followed by start leaves the block in IDLE with running=0.
- Pause/resume: pause 4 cycles after start, hold for 50 cycles, then resume. The first decrement occurs 6 RUN cycles after resume.
- Strobe priority:
  - load and start in the same cycle → IDLE with the preset loaded.
  - pause coincident with a tick → count updated and state PAUSE.
- Reset and warning:
  - rstn low mid-run → all outputs 0 immediately.
  - With TIMER_WARN_EN and WARN_SEC=10, down count from 0:12: warn rises when count=10 and falls at 0.
